w_fetch_seq: RTL and testbench

W_FETCH_SEQ -- requirements
Module: w_fetch_seq

---
 rtl/fnn_pkg.sv | 12 +
 rtl/w_skid_fifo.sv | 60 ++++++
 rtl/w_fetch_seq.sv | 121 ++++++++++++
 tb/tb_w_fetch_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fnn_pkg.sv
// Shared defaults and types for the feed-forward NN weight path.
package fnn_pkg;

   localparam int FNN_DATA_W = 16;

   typedef enum logic [1:0] {
      WF_IDLE  = 2'd0,
      WF_FETCH = 2'd1,
      WF_DRAIN = 2'd2
   } wf_state_t;

endpackage

// File: rtl/w_skid_fifo.sv
// Two-entry FIFO, flow-through when empty (zero latency); head holds while out_rdy is low.
// Writes are never refused: the producer keeps occupancy plus outstanding writes <= 2.
module w_skid_fifo #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   output logic [W-1:0] out_dat,
   input  logic         out_rdy,
   output logic [1:0]   cnt
);

   logic [W-1:0] ent0;
   logic [W-1:0] ent1;
   logic [1:0]   cnt_q;
   logic         empty;
   logic         push;
   logic         pop;

   assign empty   = (cnt_q == 2'd0);
   assign out_vld = empty ? in_vld : 1'b1;
   assign out_dat = empty ? (in_vld ? in_dat : '0) : ent0;
   assign pop     = !empty && out_rdy;
   // An empty FIFO with a ready consumer passes the word straight through.
   assign push    = in_vld && !(empty && out_rdy);
   assign cnt     = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0  <= '0;
         ent1  <= '0;
         cnt_q <= 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (empty) ent0 <= in_dat;
               else       ent1 <= in_dat;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               ent0  <= ent1;
               cnt_q <= cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  ent0 <= in_dat;
               end else begin
                  ent0 <= ent1;
                  ent1 <= in_dat;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/w_fetch_seq.sv
// Weight fetch sequencer: streams NUM_WEIGHT words to the MAC, first beat 2 cycles after start, w_ready backpressure.
// Optional W_FETCH_CHECKSUM_EN adds a wrap-around sum of delivered weights on w_sum.
module w_fetch_seq
   import fnn_pkg::*;
#(
   parameter int NUM_WEIGHT = 30,
   parameter int ADDR_W     = $clog2(NUM_WEIGHT),
   parameter int DATA_W     = FNN_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_radd,
   input  logic [DATA_W-1:0] mem_wout,
   output logic [DATA_W-1:0] w_data,
   output logic              w_valid,
   input  logic              w_ready,
   output logic              w_last,
   output logic [DATA_W-1:0] w_sum
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHT - 1);

   wf_state_t         state;
   wf_state_t         state_n;
   logic [ADDR_W-1:0] addr;
   logic              inflight;
   logic              inflight_last;
   logic              done_q;
   logic              start_acc;
   logic              issue;
   logic              hs;
   logic [1:0]        fifo_cnt;
   logic [2:0]        occ;
   logic [DATA_W:0]   head;

   assign busy      = (state != WF_IDLE);
   // The done cycle already shows busy low, but a start there is still refused.
   assign start_acc = start && (state == WF_IDLE) && !done_q;
   assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight};
   assign hs        = w_valid && w_ready;
   assign mem_ren   = issue;
   assign mem_radd  = issue ? addr : '0;
   assign done      = done_q;
   assign w_data    = head[DATA_W-1:0];
   assign w_last    = head[DATA_W];

   always_comb begin
      state_n = state;
      issue   = 1'b0;
      unique case (state)
         WF_IDLE: begin
            if (start_acc) state_n = WF_FETCH;
         end
         WF_FETCH: begin
            // Never let buffered plus returning words exceed the two FIFO slots.
            if (occ < 3'd2) begin
               issue = 1'b1;
               if (addr == LAST_ADDR) state_n = WF_DRAIN;
            end
         end
         WF_DRAIN: begin
            if (hs && w_last) state_n = WF_IDLE;
         end
         default: state_n = WF_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= WF_IDLE;
         addr          <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state         <= state_n;
         inflight      <= issue;
         inflight_last <= issue && (addr == LAST_ADDR);
         done_q        <= (state == WF_DRAIN) && hs && w_last;
         if (start_acc)
            addr <= '0;
         else if (issue)
            addr <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
      end
   end

   w_skid_fifo #(
      .W (DATA_W + 1)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (inflight),
      .in_dat  ({inflight_last, mem_wout}),
      .out_vld (w_valid),
      .out_dat (head),
      .out_rdy (w_ready),
      .cnt     (fifo_cnt)
   );

`ifdef W_FETCH_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sum_q <= '0;
      else if (start_acc)
         sum_q <= '0;
      else if (hs)
         sum_q <= sum_q + w_data;
   end

   assign w_sum = sum_q;
`else
   assign w_sum = '0;
`endif

endmodule

// File: tb/tb_w_fetch_seq.sv
// Bench for w_fetch_seq with NUM_WEIGHT=10: directed and random passes against a beat-level reference model.
module tb_w_fetch_seq;

   localparam int NW = 10;
   localparam int AW = 4;
   localparam int DW = 16;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          start    = 1'b0;
   logic          w_ready  = 1'b0;
   logic [DW-1:0] mem_wout = '0;
   logic          busy;
   logic          done;
   logic          mem_ren;
   logic [AW-1:0] mem_radd;
   logic [DW-1:0] w_data;
   logic          w_valid;
   logic          w_last;
   logic [DW-1:0] w_sum;

   logic [DW-1:0] mem [NW];
   int total = 0;
   int bad   = 0;

   w_fetch_seq #(
      .NUM_WEIGHT (NW),
      .ADDR_W     (AW),
      .DATA_W     (DW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .mem_ren  (mem_ren),
      .mem_radd (mem_radd),
      .mem_wout (mem_wout),
      .w_data   (w_data),
      .w_valid  (w_valid),
      .w_ready  (w_ready),
      .w_last   (w_last),
      .w_sum    (w_sum)
   );

   always #5 clk = ~clk;

   // Synchronous-read weight memory: data one cycle after the read enable.
   always @(posedge clk) if (mem_ren) mem_wout <= mem[mem_radd];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "/busy"},     busy,     0);
      chk({nm, "/done"},     done,     0);
      chk({nm, "/mem_ren"},  mem_ren,  0);
      chk({nm, "/mem_radd"}, mem_radd, 0);
      chk({nm, "/w_data"},   w_data,   0);
      chk({nm, "/w_valid"},  w_valid,  0);
      chk({nm, "/w_last"},   w_last,   0);
      chk({nm, "/w_sum"},    w_sum,    0);
   endtask

   // mode: 0 ready held high, 1 alternating 1/0, 2 five-cycle stall at beat 4, other random.
   task automatic run_pass(input int mode, input bit collide, input string nm);
      int            cyc = 0;
      int            beats = 0;
      int            issued = 0;
      int            first_ren = -1;
      int            first_vld = -1;
      int            last_hs = -1;
      int            stall_left = 0;
      bit            stalled = 0;
      bit            prev_stall = 0;
      bit            exp_done;
      bit            exp_busy;
      logic [DW-1:0] prev_dat = '0;
      logic [DW-1:0] exp_sum = '0;
      for (int i = 0; i < NW; i++) exp_sum += mem[i];

      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 300 && !(last_hs >= 0 && cyc > last_hs + 3)) begin
         start = collide && (cyc == 4 || (last_hs >= 0 && cyc == last_hs + 1));
         case (mode)
            0: w_ready = 1'b1;
            1: w_ready = cyc[0];
            2: begin
               if (beats == 4 && !stalled) begin
                  stalled = 1;
                  stall_left = 5;
               end
               if (stall_left > 0) begin
                  w_ready = 1'b0;
                  stall_left--;
               end else begin
                  w_ready = 1'b1;
               end
            end
            default: w_ready = 1'($urandom_range(0, 1));
         endcase

         @(negedge clk);
         exp_done = (last_hs >= 0 && cyc == last_hs + 1);
         exp_busy = !(last_hs >= 0 && cyc > last_hs);
         chk({nm, "/busy"}, busy, exp_busy);
         chk({nm, "/done"}, done, exp_done);

         if (mem_ren) begin
            chk({nm, "/radd"}, mem_radd, issued);
            chk({nm, "/occupancy"}, (issued - beats) < 2, 1);
            chk({nm, "/extra_read"}, issued < NW, 1);
            if (first_ren < 0) first_ren = cyc;
            issued++;
         end else begin
            chk({nm, "/radd_idle"}, mem_radd, 0);
         end

         if (prev_stall) begin
            chk({nm, "/valid_hold"}, w_valid, 1);
            chk({nm, "/data_hold"}, w_data, prev_dat);
         end
         if (w_valid) begin
            if (first_vld < 0) first_vld = cyc;
            chk({nm, "/extra_beat"}, beats < NW, 1);
            if (beats < NW) begin
               chk({nm, "/data"}, w_data, mem[beats]);
               chk({nm, "/last"}, w_last, beats == NW - 1);
            end
            if (w_ready) begin
               beats++;
               if (beats == NW) last_hs = cyc;
            end
         end
         prev_stall = w_valid && !w_ready;
         prev_dat   = w_data;

`ifdef W_FETCH_CHECKSUM_EN
         if (cyc == 1) chk({nm, "/sum_clear"}, w_sum, 0);
         if (last_hs >= 0 && cyc > last_hs) chk({nm, "/sum"}, w_sum, exp_sum);
`else
         chk({nm, "/sum_off"}, w_sum, 0);
`endif

         @(posedge clk); #1;
         cyc++;
      end
      start   = 1'b0;
      w_ready = 1'b0;
      chk({nm, "/timeout"}, last_hs >= 0, 1);
      chk({nm, "/reads"}, issued, NW);
      if (mode == 0) begin
         chk({nm, "/first_ren"}, first_ren, 1);
         chk({nm, "/first_vld"}, first_vld, 2);
         chk({nm, "/back_to_back"}, last_hs, first_vld + NW - 1);
      end
   endtask

   initial begin
      for (int i = 0; i < NW; i++) mem[i] = 16'(i + 1);

      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_pass(0, 1'b0, "stream");
      run_pass(1, 1'b0, "alternate");
      run_pass(2, 1'b0, "stall");
      run_pass(0, 1'b1, "collide");

      for (int i = 0; i < NW; i++) mem[i] = 16'hFFFF;
      run_pass(0, 1'b0, "all_ones");

      // Abandon a pass mid-fetch, then confirm the next pass starts from address 0.
      for (int i = 0; i < NW; i++) mem[i] = 16'(i + 1);
      @(posedge clk); #1;
      start   = 1'b1;
      w_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("midrst/pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      w_ready = 1'b0;
      rst_n   = 1'b1;
      run_pass(0, 1'b0, "after_rst");

      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
         run_pass(3, p == 3, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
